// File: rtl/serial_ripple_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = (a - b) mod 2^WIDTH, one bit per clock,
// LSB first, behind a start/busy/done handshake.
module serial_ripple_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);

  // Handshake: start is looked at only in IDLE and accepted on that edge; a/b are
  // captured on the accepting edge only. busy covers RUN and DONE; done is a
  // one-cycle pulse in DONE while diff/borrow_out/zero hold the fresh result.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr, r_next;
  logic [CW-1:0]    cnt;
  logic             bin, ai, bi, d, bnext, last_bit;

  // Full-subtractor cell on the current operand LSBs.
  always_comb begin
    ai       = a_sr[0];
    bi       = b_sr[0];
    d        = ai ^ bi ^ bin;
    bnext    = (~ai & bi) | (~(ai ^ bi) & bin);
    r_next   = {d, r_sr[WIDTH-1:1]};
    last_bit = (cnt == LAST);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      r_sr       <= '0;
      bin        <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      zero       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr <= a;
            b_sr <= b;
            r_sr <= '0;
            bin  <= 1'b0;
            cnt  <= '0;
          end
        end
        RUN: begin
          r_sr <= r_next;
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          bin  <= bnext;
          cnt  <= last_bit ? '0 : cnt + CW'(1);
          // Published outputs move only on the edge that enters DONE.
          if (last_bit) begin
            diff       <= r_next;
            borrow_out <= bnext;
            zero       <= (r_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
